mem_arbiter: RTL and testbench

- Shares the single-port word memory between the CPU instruction-fetch port (read-only) and the load/store data port (read/write with byte strobes).
- Arbitrates round-robin and returns registered responses.
- Converts partial-word stores into a two-cycle read-modify-write, because the memory only supports full-word writes.
- Sits between the core and the memory: the memory has a combinational read and a write on the rising clock edge; words are indexed by addr[11:2].

---
 rtl/mem_pkg.sv | 22 ++
 rtl/byte_merge.sv | 27 ++
 rtl/mem_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the memory arbiter and its helpers.
//   state_t    : arbiter FSM encoding (IDLE, MERGE)
//   prio_t     : round-robin priority pointer (PRIO_DATA, PRIO_FETCH)
//   WORD_BYTES : bytes per memory word
// -----------------------------------------------------------------------------
package mem_pkg;

    localparam int WORD_BYTES = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        MERGE = 1'b1
    } state_t;

    typedef enum logic {
        PRIO_DATA  = 1'b0,
        PRIO_FETCH = 1'b1
    } prio_t;

endpackage

// File: rtl/byte_merge.sv
// -----------------------------------------------------------------------------
// byte_merge
// Combinational per-byte select between new and old word data.
//   i_new  : replacement data, taken for bytes whose strobe bit is set
//   i_old  : existing data, kept for bytes whose strobe bit is clear
//   i_strb : byte strobes, bit n covers bits [8n+7:8n]
//   o_data : merged word
// -----------------------------------------------------------------------------
module byte_merge
    import mem_pkg::*;
(
    input  logic [31:0]           i_new,
    input  logic [31:0]           i_old,
    input  logic [WORD_BYTES-1:0] i_strb,
    output logic [31:0]           o_data
);

    always_comb begin
        o_data = i_old;
        for (int b = 0; b < WORD_BYTES; b++) begin
            if (i_strb[b]) begin
                o_data[8*b +: 8] = i_new[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one single-port word memory between the instruction-fetch port
// (read-only) and the load/store data port. Partial stores become a
// read-modify-write through the MERGE state.
//
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   i_req/i_addr          : fetch request and address
//   i_gnt/i_rvalid/i_rdata: fetch accept, response pulse, read data
//   d_req/d_we/d_strb/
//   d_addr/d_wdata        : data request, store flag, byte strobes, addr, data
//   d_gnt/d_rvalid/d_rdata: data accept, response pulse, load data (0 on store)
//   mem_we/mem_addr/
//   mem_wdata/mem_rdata   : memory interface (combinational read, clocked write)
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | arbitrate; reads, full/empty stores complete here in one cycle
// MERGE | write latched partial store merged with current memory word
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter bit RR_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [31:0]       i_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_strb,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,

    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    state_t              r_state;
    state_t              w_state_nxt;
    prio_t               r_prio;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic [3:0]          r_strb;

    logic                w_d_win;
    logic                w_i_win;
    logic                w_strb_full;
    logic                w_strb_empty;
    logic                w_partial;
    logic [31:0]         w_merged;

    assign w_strb_full  = &d_strb;
    assign w_strb_empty = ~|d_strb;
    assign w_partial    = d_we & ~w_strb_full & ~w_strb_empty;

    // Data port wins when alone, when fixed priority is selected, or when
    // the round-robin pointer names it.
    assign w_d_win = (r_state == IDLE) & d_req &
                     (~i_req | ~RR_EN | (r_prio == PRIO_DATA));
    assign w_i_win = (r_state == IDLE) & i_req & ~w_d_win;

    byte_merge u_byte_merge (
        .i_new  (r_wdata),
        .i_old  (mem_rdata),
        .i_strb (r_strb),
        .o_data (w_merged)
    );

    always_comb begin
        w_state_nxt = r_state;
        i_gnt       = 1'b0;
        d_gnt       = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = i_addr;
        mem_wdata   = d_wdata;
        case (r_state)
            IDLE: begin
                if (w_d_win) begin
                    d_gnt    = 1'b1;
                    mem_addr = d_addr;
                    if (d_we && w_strb_full) begin
                        mem_we = 1'b1;
                    end else if (w_partial) begin
                        w_state_nxt = MERGE;
                    end
                end else if (w_i_win) begin
                    i_gnt = 1'b1;
                end
            end
            MERGE: begin
                mem_addr    = r_addr;
                mem_wdata   = w_merged;
                mem_we      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_prio   <= PRIO_DATA;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_strb   <= '0;
            i_rvalid <= 1'b0;
            i_rdata  <= '0;
            d_rvalid <= 1'b0;
            d_rdata  <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (RR_EN) begin
                if (d_gnt) begin
                    r_prio <= PRIO_FETCH;
                end else if (i_gnt) begin
                    r_prio <= PRIO_DATA;
                end
            end

            if (d_gnt && w_partial) begin
                r_addr  <= d_addr;
                r_wdata <= d_wdata;
                r_strb  <= d_strb;
            end

            i_rvalid <= i_gnt;
            if (i_gnt) begin
                i_rdata <= mem_rdata;
            end

            // Partial stores respond after MERGE, everything else right after grant.
            d_rvalid <= (d_gnt & ~w_partial) | (r_state == MERGE);
            if (d_gnt) begin
                d_rdata <= d_we ? 32'h0 : mem_rdata;
            end else if (r_state == MERGE) begin
                d_rdata <= 32'h0;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_strb;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:1023];
    logic        preload;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .RR_EN(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_gnt     (i_gnt),
        .i_rvalid  (i_rvalid),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_strb    (d_strb),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    assign mem_rdata = mem[mem_addr[11:2]];

    always @(posedge clk) begin
        if (preload) mem[10'h010] <= 32'hAABBCCDD;
        else if (mem_we) mem[mem_addr[11:2]] <= mem_wdata;
    end

    typedef struct {
        int          due;
        logic [31:0] data;
    } rsp_t;

    rsp_t        iq[$];
    rsp_t        dq[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [31:0] ref_mem [0:1023];
    logic        merge_pend = 1'b0;
    logic [31:0] merge_addr;
    logic [31:0] merge_word;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge_ref(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  s);
        logic [31:0] m;
        m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (new_w & m) | (old_w & ~m);
    endfunction

    // One clock cycle: check combinational outputs against the expected grant,
    // record expected responses, then check registered responses after the edge.
    task automatic step(input logic ei, input logic ed);
        logic exp_we;
        #1;
        chk("i_gnt", {31'b0, i_gnt}, {31'b0, ei});
        chk("d_gnt", {31'b0, d_gnt}, {31'b0, ed});
        chk("gnt_excl", {31'b0, i_gnt & d_gnt}, 32'h0);
        exp_we = 1'b0;
        if (merge_pend) begin
            exp_we = 1'b1;
            chk("merge_addr", mem_addr, merge_addr);
            chk("merge_wdata", mem_wdata, merge_word);
            ref_mem[merge_addr[11:2]] = merge_word;
            merge_pend = 1'b0;
            dq.push_back('{cyc + 1, 32'h0});
        end else if (ed) begin
            chk("d_mem_addr", mem_addr, d_addr);
            if (d_we) begin
                if (d_strb == 4'hF) begin
                    exp_we = 1'b1;
                    chk("full_wdata", mem_wdata, d_wdata);
                    ref_mem[d_addr[11:2]] = d_wdata;
                    dq.push_back('{cyc + 1, 32'h0});
                end else if (d_strb == 4'h0) begin
                    dq.push_back('{cyc + 1, 32'h0});
                end else begin
                    merge_pend = 1'b1;
                    merge_addr = d_addr;
                    merge_word = merge_ref(ref_mem[d_addr[11:2]], d_wdata, d_strb);
                end
            end else begin
                dq.push_back('{cyc + 1, ref_mem[d_addr[11:2]]});
            end
        end else begin
            chk("i_mem_addr", mem_addr, i_addr);
            if (ei) iq.push_back('{cyc + 1, ref_mem[i_addr[11:2]]});
        end
        chk("mem_we", {31'b0, mem_we}, {31'b0, exp_we});
        @(posedge clk);
        cyc++;
        #1;
        if (iq.size() > 0 && iq[0].due == cyc) begin
            chk("i_rvalid", {31'b0, i_rvalid}, 32'h1);
            chk("i_rdata", i_rdata, iq[0].data);
            void'(iq.pop_front());
        end else begin
            chk("i_rvalid_quiet", {31'b0, i_rvalid}, 32'h0);
        end
        if (dq.size() > 0 && dq[0].due == cyc) begin
            chk("d_rvalid", {31'b0, d_rvalid}, 32'h1);
            chk("d_rdata", d_rdata, dq[0].data);
            void'(dq.pop_front());
        end else begin
            chk("d_rvalid_quiet", {31'b0, d_rvalid}, 32'h0);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        iq.delete();
        dq.delete();
        merge_pend = 1'b0;
        @(negedge clk);
        chk("rst_i_rvalid", {31'b0, i_rvalid}, 32'h0);
        chk("rst_d_rvalid", {31'b0, d_rvalid}, 32'h0);
        chk("rst_i_rdata", i_rdata, 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'h0);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n   = 1'b0;
        preload = 1'b1;
        i_req   = 1'b0;
        i_addr  = 32'h0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_strb  = 4'h0;
        d_addr  = 32'h0;
        d_wdata = 32'h0;
        ref_mem[10'h010] = 32'hAABBCCDD;
        @(negedge clk);
        preload = 1'b0;
        do_reset();

        // Fetch read
        i_req = 1'b1; i_addr = 32'h40;
        step(1'b1, 1'b0);
        i_req = 1'b0;
        step(1'b0, 1'b0);

        // Contention after reset: D, I, D, I
        do_reset();
        i_req = 1'b1; i_addr = 32'h40;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        i_req = 1'b0; d_req = 1'b0;
        step(1'b0, 1'b0);

        // Partial store with a fetch arriving during MERGE
        d_req = 1'b1; d_we = 1'b1; d_strb = 4'b0101; d_addr = 32'h40; d_wdata = 32'h11223344;
        step(1'b0, 1'b1);
        d_req = 1'b0;
        i_req = 1'b1; i_addr = 32'h40;
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        i_req = 1'b0;
        chk("merge_word", mem[10'h010], 32'hAA22CC44);
        d_req = 1'b1; d_we = 1'b0;
        step(1'b0, 1'b1);
        d_req = 1'b0;
        step(1'b0, 1'b0);

        // Full store then empty store back to back
        d_req = 1'b1; d_we = 1'b1; d_strb = 4'hF; d_wdata = 32'hDEADBEEF;
        step(1'b0, 1'b1);
        d_strb = 4'h0; d_wdata = 32'h0;
        step(1'b0, 1'b1);
        d_req = 1'b0;
        step(1'b0, 1'b0);
        chk("full_store_word", mem[10'h010], 32'hDEADBEEF);

        // Reset during MERGE abandons the write
        d_req = 1'b1; d_we = 1'b1; d_strb = 4'b0010; d_wdata = 32'h55667788;
        step(1'b0, 1'b1);
        d_req = 1'b0;
        #1;
        chk("merge_we_before_rst", {31'b0, mem_we}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_we", {31'b0, mem_we}, 32'h0);
        merge_pend = 1'b0;
        iq.delete();
        dq.delete();
        @(posedge clk);
        #1;
        chk("rst_no_d_rvalid", {31'b0, d_rvalid}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_word_kept", mem[10'h010], 32'hDEADBEEF);

        // Priority back to DATA after reset
        i_req = 1'b1; i_addr = 32'h40;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        i_req = 1'b0; d_req = 1'b0;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
